// File: rtl/aes128_iter_core_if.sv
// Block handshake bus between the plaintext source, the AES core and the ciphertext sink.
interface aes128_iter_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;
    logic [3:0]   round_cnt;

    modport master (
        output in_valid, data_in, key_in, out_ready,
        input  in_ready, out_valid, data_out, busy, round_cnt
    );

    modport slave (
        input  in_valid, data_in, key_in, out_ready,
        output in_ready, out_valid, data_out, busy, round_cnt
    );
endinterface

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryption core: one shared round datapath, on-the-fly key expansion.
// Optional round tap outputs enabled by defining AES_ROUND_TAP_EN.
module aes128_iter_core #(
    parameter int unsigned NR = 10
) (
    input  logic                clk,
    input  logic                reset,
`ifdef AES_ROUND_TAP_EN
    output logic                tap_valid,
    output logic [127:0]        tap_state,
    output logic [127:0]        tap_key,
`endif
    aes128_iter_core_if.slave   bus
);

    localparam logic [3:0] NR_L = 4'(NR);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} state_e;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] sb_q;
    logic [31:0]  sw_q;

    logic [127:0] sr, mc, nk;
    logic [31:0]  temp;
    logic         last_round;

    // Round datapath: ShiftRows/MixColumns on the registered S-box bytes, next round key.
    always_comb begin
        sr = '0;
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127 - 8*(4*c + r) -: 8] = sb_q[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[127 - 32*c -: 32] = mix_col(sr[127 - 32*c -: 32]);
        end
        temp            = sw_q ^ {rcon_q, 24'h0};
        nk[127:96]      = rk_q[127:96] ^ temp;
        nk[95:64]       = rk_q[95:64] ^ nk[127:96];
        nk[63:32]       = rk_q[63:32] ^ nk[95:64];
        nk[31:0]        = rk_q[31:0]  ^ nk[63:32];
        last_round      = (round_q == NR_L);
    end

    // NOTE: every always_comb output gets a default first and uses blocking '=' only, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rk_d    = rk_q;
        rcon_d  = rcon_q;
        round_d = round_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    st_d    = bus.data_in ^ bus.key_in;
                    rk_d    = bus.key_in;
                    rcon_d  = 8'h01;
                    round_d = 4'd1;
                    state_d = SUB;
                end
            end
            SUB: state_d = MIX;
            MIX: begin
                st_d   = (last_round ? sr : mc) ^ nk;
                rk_d   = nk;
                rcon_d = xtime(rcon_q);
                if (last_round) begin
                    round_d = 4'd0;
                    state_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = SUB;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            st_q    <= '0;
            rk_q    <= '0;
            rcon_q  <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            rcon_q  <= rcon_d;
            round_q <= round_d;
        end
    end

    // NOTE: S-box lookup registers have no reset; SUB always rewrites them before MIX reads them.
    always_ff @(posedge clk) begin
        if (state_q == SUB) begin
            for (int i = 0; i < 16; i++) begin
                sb_q[127 - 8*i -: 8] <= sbox(st_q[127 - 8*i -: 8]);
            end
            sw_q <= {sbox(rk_q[23:16]), sbox(rk_q[15:8]), sbox(rk_q[7:0]), sbox(rk_q[31:24])};
        end
    end

    assign bus.in_ready  = reset && (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.data_out  = (state_q == DONE) ? st_q : '0;
    assign bus.busy      = (state_q != IDLE);
    assign bus.round_cnt = round_q;

`ifdef AES_ROUND_TAP_EN
    logic         tap_valid_q;
    logic [127:0] tap_state_q, tap_key_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tap_valid_q <= 1'b0;
            tap_state_q <= '0;
            tap_key_q   <= '0;
        end else begin
            tap_valid_q <= (state_q == MIX);
            if (state_q == MIX) begin
                tap_state_q <= st_d;
                tap_key_q   <= nk;
            end
        end
    end

    assign tap_valid = tap_valid_q;
    assign tap_state = tap_state_q;
    assign tap_key   = tap_key_q;
`endif

endmodule
